address_encoder_top: RTL and testbench

// - Master-side counterpart of the slave address decoder: serialises {I2C_addr[6:0], rw} MSB-first onto SDA and samples the slave's ACK.
// - Sits in the master datapath after START generation and before the data byte transmitter/receiver.
// - Drives SDA open-drain style: SDA_drive_low=1 pulls the line low; 0 releases it.

---
 rtl/i2c_pkg.sv | 9 +
 rtl/address_encoder_controller.sv | 112 +++++++++++
 rtl/counter.sv | 17 +
 rtl/address_encoder_top.sv | 56 +++++
 tb/tb_address_encoder_top.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and sizes for the I2C master address transmitter.
// The optional arbitration check is built when ADDR_TX_ARB_EN is defined.
package i2c_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, ACK, DONE} addr_tx_state_t;
   localparam int ADDR_WIDTH = 7;
   localparam int FRAME_BITS = ADDR_WIDTH + 1;
   localparam int CNT_WIDTH  = 4;
   localparam logic [CNT_WIDTH-1:0] LAST_FALL = CNT_WIDTH'(FRAME_BITS - 1);
endpackage

// File: rtl/address_encoder_controller.sv
// FSM, shift register and registered outputs of the address transmitter.
// ADDR_TX_ARB_EN adds arbitration-loss detection during SHIFT.
module address_encoder_controller
   import i2c_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scl,
   input  logic                  scl_prev,
   input  logic                  sda,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] i2c_addr,
   input  logic                  rw,
   input  logic [CNT_WIDTH-1:0]  count,
   output logic                  cnt_clr,
   output logic                  cnt_en,
   output logic                  sda_drive_low,
   output logic                  busy,
   output logic                  done,
   output logic                  ack
`ifdef ADDR_TX_ARB_EN
   ,
   output logic                  arb_lost
`endif
);
   localparam int MSB = FRAME_BITS - 1;

   addr_tx_state_t        state;
   logic [FRAME_BITS-1:0] shreg;
   logic                  fall;
   logic                  rise;
   logic                  active;

   assign fall    = scl_prev & ~scl;
   assign rise    = ~scl_prev & scl;
   assign active  = (state == SHIFT) || (state == ACK);
   assign cnt_en  = (state == SHIFT) && enable && fall;
   assign cnt_clr = ((state == IDLE) && enable) || (active && !enable);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         shreg         <= '0;
         sda_drive_low <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         ack           <= 1'b0;
`ifdef ADDR_TX_ARB_EN
         arb_lost      <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (enable) begin
                  shreg         <= {i2c_addr, rw};
                  sda_drive_low <= ~i2c_addr[ADDR_WIDTH-1];
                  busy          <= 1'b1;
                  state         <= SHIFT;
               end
            end
            SHIFT: begin
               if (!enable) begin
                  sda_drive_low <= 1'b0;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
`ifdef ADDR_TX_ARB_EN
               // Released bit read back low: another master owns the bus.
               else if (rise && shreg[MSB] && !sda) begin
                  arb_lost      <= 1'b1;
                  sda_drive_low <= 1'b0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  ack           <= 1'b0;
                  state         <= DONE;
               end
`endif
               else if (fall) begin
                  shreg <= {shreg[MSB-1:0], 1'b0};
                  if (count == LAST_FALL) begin
                     sda_drive_low <= 1'b0;
                     state         <= ACK;
                  end else begin
                     sda_drive_low <= ~shreg[MSB-1];
                  end
               end
            end
            ACK: begin
               if (!enable) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (rise) begin
                  ack   <= ~sda;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               if (!enable) begin
                  done  <= 1'b0;
`ifdef ADDR_TX_ARB_EN
                  arb_lost <= 1'b0;
`endif
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/counter.sv
// Generic up-counter with synchronous clear; counts SCL falls in a frame.
module counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);
   always_ff @(posedge clk) begin
      if (!rst || clr)
         count <= '0;
      else if (en)
         count <= count + WIDTH'(1);
   end
endmodule

// File: rtl/address_encoder_top.sv
// Serialises {addr, rw} onto SDA and samples the slave ACK (structural).
// Define ADDR_TX_ARB_EN to add the arb_lost output.
module address_encoder_top
   import i2c_pkg::*;
(
   input  logic                  FPGA_clk,
   input  logic                  rst,
   input  logic                  SCL,
   input  logic                  SCL_prev,
   input  logic                  SDA,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] I2C_addr,
   input  logic                  rw,
   output logic                  SDA_drive_low,
   output logic                  busy,
   output logic                  done,
   output logic                  ack
`ifdef ADDR_TX_ARB_EN
   ,
   output logic                  arb_lost
`endif
);
   logic [CNT_WIDTH-1:0] count;
   logic                 cnt_clr;
   logic                 cnt_en;

   counter #(.WIDTH(CNT_WIDTH)) u_counter (
      .clk   (FPGA_clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (count)
   );

   address_encoder_controller u_ctrl (
      .clk           (FPGA_clk),
      .rst           (rst),
      .scl           (SCL),
      .scl_prev      (SCL_prev),
      .sda           (SDA),
      .enable        (enable),
      .i2c_addr      (I2C_addr),
      .rw            (rw),
      .count         (count),
      .cnt_clr       (cnt_clr),
      .cnt_en        (cnt_en),
      .sda_drive_low (SDA_drive_low),
      .busy          (busy),
      .done          (done),
      .ack           (ack)
`ifdef ADDR_TX_ARB_EN
      ,
      .arb_lost      (arb_lost)
`endif
   );
endmodule

// File: tb/tb_address_encoder_top.sv
// Self-checking bench for address_encoder_top with a wired-AND bus model.
// Expected line bits and ACK values are queued at frame start.
module tb_address_encoder_top;
   logic       FPGA_clk = 1'b0;
   logic       rst;
   logic       SCL;
   logic       SCL_prev;
   logic       SDA;
   logic       enable;
   logic [6:0] I2C_addr;
   logic       rw;
   logic       SDA_drive_low;
   logic       busy;
   logic       done;
   logic       ack;
`ifdef ADDR_TX_ARB_EN
   logic       arb_lost;
`endif
   logic       slave_low;
   logic       force_low;

   int vectors = 0;
   int errors  = 0;
   bit exp_q[$];

   address_encoder_top dut (
      .FPGA_clk      (FPGA_clk),
      .rst           (rst),
      .SCL           (SCL),
      .SCL_prev      (SCL_prev),
      .SDA           (SDA),
      .enable        (enable),
      .I2C_addr      (I2C_addr),
      .rw            (rw),
      .SDA_drive_low (SDA_drive_low),
      .busy          (busy),
      .done          (done),
      .ack           (ack)
`ifdef ADDR_TX_ARB_EN
      ,
      .arb_lost      (arb_lost)
`endif
   );

   always #5 FPGA_clk = ~FPGA_clk;
   always @(posedge FPGA_clk) SCL_prev <= SCL;
   // Open-drain bus: any pull-down wins.
   assign SDA = !(SDA_drive_low || slave_low || force_low);

   task automatic tick(input int n);
      repeat (n) @(negedge FPGA_clk);
   endtask

   task automatic start_frame(input logic [6:0] a, input logic r,
                              input bit exp_ack);
      logic [7:0] f;
      f = {a, r};
      for (int i = 7; i >= 0; i--) exp_q.push_back(f[i]);
      exp_q.push_back(exp_ack);
      I2C_addr = a;
      rw       = r;
      enable   = 1'b1;
      tick(1);
      vectors++;
      if (busy !== 1'b1 || SDA_drive_low !== !f[7] || done !== 1'b0) begin
         errors++;
         $display("FAIL load busy=%b drive=%b done=%b required 1 %b 0",
                  busy, SDA_drive_low, done, !f[7]);
      end
   endtask

   task automatic shift_bits(input int n, input int first, input int frc);
      bit exp;
      bit fr;
      for (int i = 0; i < n; i++) begin
         fr  = (first + i == frc);
         exp = exp_q.pop_front();
         tick(3);
         force_low = fr;
         SCL = 1'b1;
         tick(2);
         vectors++;
         if (SDA !== (exp & !fr) || SDA_drive_low !== !exp) begin
            errors++;
            $display("FAIL bit%0d line=%b drive=%b required line=%b drive=%b",
                     first + i, SDA, SDA_drive_low, exp & !fr, !exp);
         end
         tick(2);
         force_low = 1'b0;
         SCL = 1'b0;
         tick(1);
      end
   endtask

   task automatic ack_slot(input bit slave_acks);
      bit exp;
      exp = exp_q.pop_front();
      slave_low = slave_acks;
      tick(3);
      vectors++;
      if (SDA_drive_low !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ack_pre drive=%b done=%b busy=%b required 0 0 1",
                  SDA_drive_low, done, busy);
      end
      SCL = 1'b1;
      tick(1);
      vectors++;
      if (done !== 1'b1 || ack !== exp || busy !== 1'b0) begin
         errors++;
         $display("FAIL ack_done done=%b ack=%b busy=%b required 1 %b 0",
                  done, ack, busy, exp);
      end
      tick(2);
      SCL = 1'b0;
      tick(1);
      slave_low = 1'b0;
   endtask

   task automatic finish_frame();
      enable = 1'b0;
      tick(1);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || SDA_drive_low !== 1'b0) begin
         errors++;
         $display("FAIL release done=%b busy=%b drive=%b required 0 0 0",
                  done, busy, SDA_drive_low);
      end
      tick(2);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      enable = 1'b0;
      SCL = 1'b0;
      I2C_addr = '0;
      rw = 1'b0;
      slave_low = 1'b0;
      force_low = 1'b0;
      tick(3);
      vectors++;
      if (SDA_drive_low !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          ack !== 1'b0) begin
         errors++;
         $display("FAIL reset drive=%b busy=%b done=%b ack=%b required 0000",
                  SDA_drive_low, busy, done, ack);
      end
`ifdef ADDR_TX_ARB_EN
      vectors++;
      if (arb_lost !== 1'b0) begin
         errors++;
         $display("FAIL reset_arb arb_lost=%b required 0", arb_lost);
      end
`endif
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_write_ack();
      start_frame(7'h50, 1'b0, 1'b1);
      shift_bits(8, 0, -1);
      ack_slot(1'b1);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         vectors++;
         if (done !== 1'b1 || ack !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_hold%0d done=%b ack=%b busy=%b required 1 1 0",
                     i, done, ack, busy);
         end
      end
      finish_frame();
   endtask

   task automatic test_read_nack();
      start_frame(7'h2A, 1'b1, 1'b0);
      shift_bits(8, 0, -1);
      ack_slot(1'b0);
      finish_frame();
   endtask

   task automatic test_reset_mid();
      start_frame(7'h50, 1'b0, 1'b1);
      shift_bits(3, 0, -1);
      rst = 1'b0;
      tick(1);
      vectors++;
      if (SDA_drive_low !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid drive=%b busy=%b done=%b required 0 0 0",
                  SDA_drive_low, busy, done);
      end
      enable = 1'b0;
      tick(1);
      rst = 1'b1;
      exp_q.delete();
      tick(2);
      start_frame(7'h50, 1'b0, 1'b1);
      shift_bits(8, 0, -1);
      ack_slot(1'b1);
      finish_frame();
   endtask

   task automatic test_abort();
      start_frame(7'h50, 1'b0, 1'b1);
      shift_bits(5, 0, -1);
      enable = 1'b0;
      tick(1);
      vectors++;
      if (SDA_drive_low !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort drive=%b busy=%b done=%b required 0 0 0",
                  SDA_drive_low, busy, done);
      end
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         tick(3);
         SCL = ~SCL;
         tick(1);
         vectors++;
         if (done !== 1'b0 || SDA_drive_low !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle%0d done=%b drive=%b required 0 0",
                     i, done, SDA_drive_low);
         end
      end
      tick(2);
   endtask

   task automatic test_addr_change();
      start_frame(7'h50, 1'b0, 1'b1);
      shift_bits(2, 0, -1);
      I2C_addr = 7'h11;
      rw = 1'b1;
      shift_bits(6, 2, -1);
      ack_slot(1'b1);
      finish_frame();
   endtask

   task automatic test_arb();
`ifdef ADDR_TX_ARB_EN
      start_frame(7'h7F, 1'b1, 1'b0);
      shift_bits(1, 0, -1);
      tick(3);
      force_low = 1'b1;
      SCL = 1'b1;
      tick(1);
      vectors++;
      if (arb_lost !== 1'b1 || done !== 1'b1 || ack !== 1'b0 ||
          SDA_drive_low !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL arb lost=%b done=%b ack=%b drive=%b busy=%b req 10000",
                  arb_lost, done, ack, SDA_drive_low, busy);
      end
      tick(2);
      force_low = 1'b0;
      SCL = 1'b0;
      tick(1);
      exp_q.delete();
      enable = 1'b0;
      tick(1);
      vectors++;
      if (arb_lost !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL arb_clear arb_lost=%b done=%b required 0 0",
                  arb_lost, done);
      end
      tick(2);
`else
      start_frame(7'h7F, 1'b1, 1'b1);
      shift_bits(8, 0, 1);
      ack_slot(1'b1);
      finish_frame();
`endif
   endtask

   initial begin
      test_reset();
      test_write_ack();
      test_read_nack();
      test_reset_mid();
      test_abort();
      test_addr_change();
      test_arb();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
